// File: rtl/amm_cdc_master_bridge.sv
// Avalon-MM agent front end for a req/ack handshake synchronizer, master clock domain.
// Holds one command on xfer_* and issues one req pulse per accepted command.
module amm_cdc_master_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   amm_address_i,
    input  logic                amm_read_i,
    input  logic                amm_write_i,
    input  logic [DATA_W-1:0]   amm_writedata_i,
    input  logic [DATA_W/8-1:0] amm_byteenable_i,
    output logic                amm_waitrequest_o,
    output logic [DATA_W-1:0]   amm_readdata_o,
    output logic                amm_readdatavalid_o,
    output logic                req_o,
    input  logic                ack_i,
    output logic [ADDR_W-1:0]   xfer_address_o,
    output logic                xfer_write_o,
    output logic [DATA_W-1:0]   xfer_writedata_o,
    output logic [DATA_W/8-1:0] xfer_byteenable_o,
    input  logic [DATA_W-1:0]   xfer_readdata_i
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                state_r;
    logic                  req_r;
    logic                  waitreq_r;
    logic                  rdv_r;
    logic [DATA_W-1:0]     rdata_r;
    logic [ADDR_W-1:0]     xfer_addr_r;
    logic                  xfer_write_r;
    logic [DATA_W-1:0]     xfer_wdata_r;
    logic [DATA_W/8-1:0]   xfer_be_r;

    logic                  cmd_s;
    logic                  ack_s;

    assign cmd_s = amm_read_i | amm_write_i;
    // An ack seen while req is still high belongs to no command of ours.
    assign ack_s = ack_i & ~req_r;

    // Command acceptance, acknowledge handling and all registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            waitreq_r    <= 1'b0;
            rdv_r        <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            xfer_addr_r  <= {ADDR_W{1'b0}};
            xfer_write_r <= 1'b0;
            xfer_wdata_r <= {DATA_W{1'b0}};
            xfer_be_r    <= {(DATA_W/8){1'b0}};
        end else begin
            req_r <= 1'b0;
            rdv_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_s) begin
                        // Write wins when both commands arrive together.
                        xfer_addr_r  <= amm_address_i;
                        xfer_write_r <= amm_write_i;
                        xfer_wdata_r <= amm_writedata_i;
                        xfer_be_r    <= amm_byteenable_i;
                        req_r        <= 1'b1;
                        waitreq_r    <= 1'b1;
                        state_r      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        waitreq_r <= 1'b0;
                        state_r   <= IDLE;
                        if (!xfer_write_r) begin
                            rdata_r <= xfer_readdata_i;
                            rdv_r   <= 1'b1;
                        end
                    end
                end
                default: begin
                    waitreq_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign amm_waitrequest_o   = waitreq_r;
    assign amm_readdata_o      = rdata_r;
    assign amm_readdatavalid_o = rdv_r;
    assign req_o               = req_r;
    assign xfer_address_o      = xfer_addr_r;
    assign xfer_write_o        = xfer_write_r;
    assign xfer_writedata_o    = xfer_wdata_r;
    assign xfer_byteenable_o   = xfer_be_r;

endmodule
